// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel prescaler, h/v position counters, sync pulses,
// display enable and frame-start strobe for the downstream colour stages.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV         = 4,
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FRONT_PORCH   = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK_PORCH    = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FRONT_PORCH   = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK_PORCH    = 33,
  parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] h_cnt,
  output logic [10:0] v_cnt,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        frame_start,
  output logic [10:0] h_visible,
  output logic [10:0] h_back_porch,
  output logic [10:0] v_visible,
  output logic [10:0] v_back_porch
);

  localparam int unsigned CW      = 11;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;

  localparam logic [DW-1:0] DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_START = CW'(H_TOTAL - H_SYNC);
  localparam logic [CW-1:0] V_SYNC_START = CW'(V_TOTAL - V_SYNC);
  localparam logic [CW-1:0] H_VIS_START  = CW'(H_BACK_PORCH);
  localparam logic [CW-1:0] H_VIS_END    = CW'(H_BACK_PORCH + H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_START  = CW'(V_BACK_PORCH);
  localparam logic [CW-1:0] V_VIS_END    = CW'(V_BACK_PORCH + V_VISIBLE);
  localparam logic          SYNC_IDLE    = (SYNC_ACTIVE_LOW != 0);
  localparam logic          TICK_RST     = (CLK_DIV == 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          video_q, video_d, frame_q, frame_d, tick_q, tick_d;
  logic          tick_c;

  // State registers; with CLK_DIV=1 the tick is pinned high even in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
      video_q <= 1'b0;
      frame_q <= 1'b0;
      tick_q  <= TICK_RST;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
    end
  end

  // Next-state counters; decoded outputs use next values so they align with the counters.
  always_comb begin
    tick_c  = (div_q == DIV_LAST);
    div_d   = tick_c ? '0 : div_q + DW'(1);
    h_d     = h_q;
    v_d     = v_q;
    frame_d = 1'b0;
    if (tick_c) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = 1'b1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
    hsync_d = (h_d >= H_SYNC_START) ? ~SYNC_IDLE : SYNC_IDLE;
    vsync_d = (v_d >= V_SYNC_START) ? ~SYNC_IDLE : SYNC_IDLE;
    video_d = (h_d >= H_VIS_START) && (h_d < H_VIS_END) &&
              (v_d >= V_VIS_START) && (v_d < V_VIS_END);
    tick_d  = (div_d == DIV_LAST);
  end

  assign h_cnt        = h_q;
  assign v_cnt        = v_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_on     = video_q;
  assign pix_tick     = tick_q;
  assign frame_start  = frame_q;
  assign h_visible    = CW'(H_VISIBLE);
  assign h_back_porch = CW'(H_BACK_PORCH);
  assign v_visible    = CW'(V_VISIBLE);
  assign v_back_porch = CW'(V_BACK_PORCH);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 16x9 raster: instance A divides by 4
// with active-low sync, instance B runs at CLK_DIV=1 with active-high sync.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [10:0] a_h, a_v, a_hvis, a_hbp, a_vvis, a_vbp;
  logic        a_hs, a_vs, a_von, a_pt, a_fs;
  logic [10:0] b_h, b_v, b_hvis, b_hbp, b_vvis, b_vbp;
  logic        b_hs, b_vs, b_von, b_pt, b_fs;

  // h: bp 0..2, visible 3..10, fp 11..12, sync 13..15; v: bp 0..1, visible 2..5, fp 6, sync 7..8
  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(3),
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(2), .SYNC_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst(rst), .h_cnt(a_h), .v_cnt(a_v), .hsync(a_hs), .vsync(a_vs),
    .video_on(a_von), .pix_tick(a_pt), .frame_start(a_fs),
    .h_visible(a_hvis), .h_back_porch(a_hbp), .v_visible(a_vvis), .v_back_porch(a_vbp)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT_PORCH(2), .H_SYNC(3), .H_BACK_PORCH(3),
    .V_VISIBLE(4), .V_FRONT_PORCH(1), .V_SYNC(2), .V_BACK_PORCH(2), .SYNC_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst(rst), .h_cnt(b_h), .v_cnt(b_v), .hsync(b_hs), .vsync(b_vs),
    .video_on(b_von), .pix_tick(b_pt), .frame_start(b_fs),
    .h_visible(b_hvis), .h_back_porch(b_hbp), .v_visible(b_vvis), .v_back_porch(b_vbp)
  );

  typedef struct {
    int unsigned n;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, von, fs, pt;
  } vec_t;

  vec_t        vecs[$];
  int unsigned n;
  int          errors = 0;
  int          checks = 0;

  function automatic vec_t mk(int unsigned n_i, int unsigned h, int unsigned v,
                              logic hs, logic vs, logic von, logic fs, logic pt);
    vec_t r;
    r.n = n_i; r.h = 11'(h); r.v = 11'(v);
    r.hs = hs; r.vs = vs; r.von = von; r.fs = fs; r.pt = pt;
    return r;
  endfunction

  // Expected {h,v,hsync,vsync,video_on,frame_start,pix_tick} n clocks after release.
  function automatic logic [26:0] model(int unsigned nn, int unsigned div, logic act_low);
    int unsigned p   = nn / div;
    int unsigned h   = p % 16;
    int unsigned v   = (p / 16) % 9;
    logic        hsa = (h >= 13);
    logic        vsa = (v >= 7);
    logic        von = (h >= 3) && (h <= 10) && (v >= 2) && (v <= 5);
    logic        fs  = (nn != 0) && (nn % (144 * div) == 0);
    logic        pt  = (div == 1) || (nn % div == div - 1);
    return {11'(h), 11'(v), hsa ^ act_low, vsa ^ act_low, von, fs, pt};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic logic [26:0] a_now();
    return {a_h, a_v, a_hs, a_vs, a_von, a_fs, a_pt};
  endfunction

  function automatic logic [26:0] b_now();
    return {b_h, b_v, b_hs, b_vs, b_von, b_fs, b_pt};
  endfunction

  initial begin
    int unsigned first_fs;
    int unsigned fs_cnt;
    //             n     h  v  hs vs von fs pt
    vecs.push_back(mk(0,    0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(3,    0, 0, 1, 1, 0, 0, 1));
    vecs.push_back(mk(4,    1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(12,   3, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(52,  13, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(63,  15, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk(64,   0, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(140,  3, 2, 1, 1, 1, 0, 0));
    vecs.push_back(mk(171, 10, 2, 1, 1, 1, 0, 1));
    vecs.push_back(mk(172, 11, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(352,  8, 5, 1, 1, 1, 0, 0));
    vecs.push_back(mk(384,  0, 6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(448,  0, 7, 1, 0, 0, 0, 0));
    vecs.push_back(mk(575, 15, 8, 0, 0, 0, 0, 1));
    vecs.push_back(mk(576,  0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(577,  0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1152, 0, 0, 1, 1, 0, 1, 0));

    // Reset held 5 clocks: reset values and constant geometry.
    repeat (5) @(posedge clk);
    #1;
    chk("reset_a", 64'(a_now()), 64'({11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    chk("reset_b", 64'(b_now()), 64'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    chk("geom_a", 64'({a_hvis, a_hbp, a_vvis, a_vbp}), 64'({11'd8, 11'd3, 11'd4, 11'd2}));
    chk("geom_b", 64'({b_hvis, b_hbp, b_vvis, b_vbp}), 64'({11'd8, 11'd3, 11'd4, 11'd2}));

    @(negedge clk);
    rst = 1'b0;
    n   = 0;
    foreach (vecs[i]) begin
      while (n < vecs[i].n) step();
      chk($sformatf("vec%0d_n%0d", i, vecs[i].n), 64'(a_now()),
          64'({vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].fs, vecs[i].pt}));
    end

    // Mid-frame reset at (6,4) takes effect without a clock edge.
    while (n < 1152 + 281) step();
    chk("pre_rst_pos", 64'(a_now()), 64'({11'd6, 11'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}));
    rst = 1'b1;
    #1;
    chk("async_rst_a", 64'(a_now()), 64'({11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    chk("async_rst_b", 64'(b_now()), 64'({11'd0, 11'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n   = 0;

    // Clock-by-clock sweep over two frames of A (eight of B) after release.
    first_fs = 0;
    fs_cnt   = 0;
    for (int k = 0; k <= 1200; k++) begin
      if (k != 0) step();
      chk($sformatf("sweep_a_n%0d", n), 64'(a_now()), 64'(model(n, 4, 1'b1)));
      chk($sformatf("sweep_b_n%0d", n), 64'(b_now()), 64'(model(n, 1, 1'b0)));
      if (a_fs) begin
        fs_cnt++;
        if (first_fs == 0) first_fs = n;
      end
    end
    chk("first_frame_start", 64'(first_fs), 64'd576);
    chk("frame_start_count", 64'(fs_cnt), 64'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
